// File: rtl/piso_pkg.sv
// Shared definitions for the piso-side byte path: arbiter state encoding and default sizing.
package piso_pkg;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig searching circularly from last_grant+1.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned     cand;
    logic [ID_W-1:0] cidx;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        cidx   = '0;
        // offset 1..NUM_REQ wraps back to last_grant itself as the lowest priority
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = ID_W'(cand);
            if (!any && elig[cidx]) begin
                any          = 1'b1;
                idx          = cidx;
                onehot[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_rr_arbiter.sv
// Round-robin burst arbiter feeding one registered byte stage into the piso input port.
module piso_rr_arbiter
    import piso_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                 pclk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ-1:0]   req_mask_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ID_W-1:0]      src_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int unsigned BEAT_W = 8;

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     gidx_q, gidx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [7:0]          data_q, data_d;
    logic [ID_W-1:0]     src_q, src_d;
    logic                valid_q, valid_d;

    logic [NUM_REQ-1:0]  elig;
    logic                slot;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [7:0]          gbyte;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic                accept;
    logic                rel;

    assign elig = req_valid_i & ~req_mask_i;
    assign slot = !valid_q || ready_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .elig       (elig),
        .last_grant (last_grant_q),
        .onehot     (pick_onehot),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Byte of the currently granted requester
    always_comb begin
        gbyte = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == ID_W'(k)) begin
                gbyte = req_data_i[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            gidx_q       <= '0;
            beat_q       <= '0;
            grant_q      <= '0;
            data_q       <= '0;
            src_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gidx_q       <= gidx_d;
            beat_q       <= beat_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            src_q        <= src_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gidx_d       = gidx_q;
        beat_d       = beat_q;
        grant_d      = grant_q;
        data_d       = data_q;
        src_d        = src_q;
        valid_d      = valid_q;
        req_ready_c  = '0;
        accept       = 1'b0;
        rel          = 1'b0;

        // The held byte drains in any state once the piso side takes it
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_GRANT;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                end
            end
            S_GRANT: begin
                req_ready_c[gidx_q] = slot && !req_mask_i[gidx_q];
                accept = req_valid_i[gidx_q] && req_ready_c[gidx_q];
                if (accept) begin
                    data_d  = gbyte;
                    src_d   = gidx_q;
                    valid_d = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                end
                rel = (accept && (beat_q == BEAT_W'(MAX_BURST - 1)))
                    || (slot && !req_valid_i[gidx_q])
                    || req_mask_i[gidx_q];
                if (rel) begin
                    state_d      = S_IDLE;
                    last_grant_d = gidx_q;
                    beat_d       = '0;
                    grant_d      = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o = req_ready_c;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign src_o       = src_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE) || valid_q;

endmodule

// File: tb/tb_piso_rr_arbiter.sv
// Directed bench for piso_rr_arbiter: vector table plus burst, backpressure and reset sequences.
module tb_piso_rr_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned ID_W      = 2;

    logic                 pclk_i = 1'b0;
    logic                 rst_n_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   req_mask_i;
    logic [7:0]           data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [ID_W-1:0]      src_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;

    piso_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .ID_W      (ID_W)
    ) dut (
        .pclk_i      (pclk_i),
        .rst_n_i     (rst_n_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_mask_i  (req_mask_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .src_o       (src_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 pclk_i = ~pclk_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  e_grant;
        logic [3:0]  e_rdy;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [1:0]  e_src;
        logic        e_busy;
    } vec_t;

    vec_t vecs [25];

    logic [3:0] pcnt [4];
    logic [3:0] ecnt [4];

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] m,
                                logic [3:0] g, logic [3:0] r, logic ev,
                                logic [7:0] ed, logic [1:0] es, logic eb);
        vec_t t;
        t.valid = v;  t.data = d;    t.mask = m;
        t.e_grant = g; t.e_rdy = r;  t.e_valid = ev;
        t.e_data = ed; t.e_src = es; t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_mask_i  = '0;
        ready_i     = 1'b1;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic drive_producers();
        for (int k = 0; k < 4; k++) begin
            req_data_i[k*8 +: 8] = {4'(k), pcnt[k]};
        end
    endtask

    logic [3:0] acc;
    logic [1:0] es;
    logic       ev;

    initial begin
        // hand-computed cycle table; all with ready_i=1
        vecs[0]  = mk(4'b0010, 32'h0000_A500, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0010, 32'h0000_A500, 4'b0000, 4'b0010, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[2]  = mk(4'b0010, 32'h0000_3C00, 4'b0000, 4'b0010, 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1);
        vecs[3]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 8'h3C, 2'd1, 1'b1);
        vecs[4]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[5]  = mk(4'b1100, 32'h3020_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[6]  = mk(4'b1100, 32'h3020_0000, 4'b0000, 4'b0100, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[7]  = mk(4'b1100, 32'h3021_0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 8'h20, 2'd2, 1'b1);
        vecs[8]  = mk(4'b1000, 32'h3000_0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 8'h21, 2'd2, 1'b1);
        vecs[9]  = mk(4'b1000, 32'h3000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[10] = mk(4'b1000, 32'h3000_0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[11] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 8'h30, 2'd3, 1'b1);
        vecs[12] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[13] = mk(4'b1001, 32'h3300_0040, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[14] = mk(4'b1001, 32'h3300_0040, 4'b0000, 4'b0001, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[15] = mk(4'b1000, 32'h3300_0000, 4'b0000, 4'b0001, 4'b0001, 1'b1, 8'h40, 2'd0, 1'b1);
        vecs[16] = mk(4'b1000, 32'h3300_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[17] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[18] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[19] = mk(4'b1000, 32'h5000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[20] = mk(4'b1000, 32'h5000_0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[21] = mk(4'b1000, 32'h5100_0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 8'h50, 2'd3, 1'b1);
        vecs[22] = mk(4'b1000, 32'h5100_0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[23] = mk(4'b1000, 32'h5100_0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[24] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

        do_reset();
        @(negedge pclk_i);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst grant", 32'(grant_o), 32'd0);
        chk("rst busy",  32'(busy_o),  32'd0);
        chk("rst data",  32'(data_o),  32'd0);
        tick();

        for (int i = 0; i < 25; i++) begin
            req_valid_i = vecs[i].valid;
            req_data_i  = vecs[i].data;
            req_mask_i  = vecs[i].mask;
            ready_i     = 1'b1;
            @(negedge pclk_i);
            chk($sformatf("v%0d grant", i), 32'(grant_o),     32'(vecs[i].e_grant));
            chk($sformatf("v%0d rdy", i),   32'(req_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d valid", i), 32'(valid_o),     32'(vecs[i].e_valid));
            chk($sformatf("v%0d busy", i),  32'(busy_o),      32'(vecs[i].e_busy));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d data", i), 32'(data_o), 32'(vecs[i].e_data));
                chk($sformatf("v%0d src", i),  32'(src_o),  32'(vecs[i].e_src));
            end
            tick();
        end

        // all four continuously valid: bursts of 4 in order 0,1,2,3,0 with one bubble
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pcnt[k] = '0;
            ecnt[k] = '0;
        end
        req_valid_i = 4'b1111;
        for (int c = 0; c < 27; c++) begin
            drive_producers();
            @(negedge pclk_i);
            acc = req_ready_o & req_valid_i;
            ev  = (c >= 2) && (((c - 2) % 5) < 4);
            es  = 2'(((c - 2) / 5) % 4);
            chk($sformatf("rr c%0d valid", c), 32'(valid_o), 32'(ev));
            if (ev) begin
                chk($sformatf("rr c%0d src", c),  32'(src_o),  32'(es));
                chk($sformatf("rr c%0d data", c), 32'(data_o), 32'({2'b00, es, ecnt[es]}));
                ecnt[es] = ecnt[es] + 4'd1;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) pcnt[k] = pcnt[k] + 4'd1;
            end
        end

        // backpressure: ready_i low for three cycles mid-burst
        do_reset();
        pcnt[0] = '0;
        ecnt[0] = '0;
        req_valid_i = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            if (c >= 16) req_valid_i = 4'b0000;
            ready_i = !(c >= 4 && c <= 6);
            drive_producers();
            @(negedge pclk_i);
            acc = req_ready_o & req_valid_i;
            if (!ready_i) begin
                chk($sformatf("bp c%0d valid", c), 32'(valid_o),     32'd1);
                chk($sformatf("bp c%0d hold", c),  32'(data_o),      32'({4'h0, ecnt[0]}));
                chk($sformatf("bp c%0d src", c),   32'(src_o),       32'd0);
                chk($sformatf("bp c%0d rdy", c),   32'(req_ready_o), 32'd0);
            end else if (valid_o) begin
                chk($sformatf("bp c%0d data", c), 32'(data_o), 32'({4'h0, ecnt[0]}));
                chk($sformatf("bp c%0d src", c),  32'(src_o),  32'd0);
                ecnt[0] = ecnt[0] + 4'd1;
            end
            tick();
            if (acc[0]) pcnt[0] = pcnt[0] + 4'd1;
        end
        chk("bp accepted vs sent", 32'(ecnt[0]), 32'(pcnt[0]));
        chk("bp drained", 32'(busy_o), 32'd0);

        // async reset while a byte is held under backpressure
        do_reset();
        req_valid_i = 4'b0100;
        req_data_i  = 32'h0077_0000;
        ready_i     = 1'b0;
        tick();
        tick();
        @(negedge pclk_i);
        chk("ar held valid", 32'(valid_o), 32'd1);
        chk("ar held data",  32'(data_o),  32'h77);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar valid", 32'(valid_o), 32'd0);
        chk("ar data",  32'(data_o),  32'd0);
        chk("ar src",   32'(src_o),   32'd0);
        chk("ar grant", 32'(grant_o), 32'd0);
        chk("ar busy",  32'(busy_o),  32'd0);
        tick();
        rst_n_i     = 1'b1;
        req_valid_i = 4'b1111;
        ready_i     = 1'b1;
        @(negedge pclk_i);
        chk("ar idle grant", 32'(grant_o), 32'd0);
        tick();
        @(negedge pclk_i);
        chk("ar first grant", 32'(grant_o), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_rr_arbiter.md
Name: piso_rr_arbiter

Overview:
- Round-robin arbiter sharing one piso byte-input port between NUM_REQ independent byte producers.
- Each requester has its own valid/ready byte stream. The arbiter grants one requester at a time for a burst of up to MAX_BURST bytes.
- It forwards the granted bytes through a one-entry registered output stage to the piso data_i/valid_i/ready_o interface, all in the pclk_i domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum bytes accepted from one requester per grant (1..255).
- ID_W, 2, width of source id; equals clog2(NUM_REQ).

Ports:
- pclk_i  input  1  single clock, rising edge.
- rst_n_i  input  1  asynchronous reset, active low.
- req_data_i  input  NUM_REQ*8  packed request bytes; requester k on bits [8k+7:8k].
- req_valid_i  input  NUM_REQ  requester k has a byte.
- req_ready_o  output  NUM_REQ  byte of requester k accepted this cycle when req_valid_i[k] is also high.
- req_mask_i  input  NUM_REQ  1 = requester disabled (configuration, quasi-static).
- data_o  output  8  byte to piso data_i.
- valid_o  output  1  to piso valid_i.
- ready_i  input  1  from piso ready_o; output transfer when valid_o && ready_i.
- src_o  output  ID_W  requester index of the byte on data_o.
- grant_o  output  NUM_REQ  one-hot current grant, 0 when idle.
- busy_o  output  1  state != S_IDLE or valid_o.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - state=S_IDLE; valid_o=0, data_o=0, src_o=0, grant_o=0, busy_o=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first; beat_cnt=0.
- Eligibility: elig = req_valid_i & ~req_mask_i.
- Slot free: slot = !valid_o || ready_i.
- S_IDLE:
  - If elig!=0, register the winner as the first set bit of elig, searching circularly from last_grant+1.
  - Set grant_o one-hot and go to S_GRANT next cycle; req_ready_o all 0 this cycle. Arbitration latency is 1 cycle.
- S_GRANT, granted index g:
  - req_ready_o[g] = slot && !req_mask_i[g], combinational; all other req_ready_o bits 0.
  - Accept = req_valid_i[g] && req_ready_o[g]. On accept, data_o<=byte g, src_o<=g, valid_o<=1, beat_cnt+1.
  - If slot && !accept, valid_o<=0 when ready_i consumed the held byte.
  - Release (go to S_IDLE, last_grant<=g, beat_cnt<=0, grant_o<=0) on any of:
    - (a) accept with beat_cnt==MAX_BURST-1;
    - (b) slot && !req_valid_i[g] (requester paused);
    - (c) req_mask_i[g]==1 (no accept that cycle).
- Output stage holds data_o/src_o stable while valid_o && !ready_i. It never drops valid_o without a transfer.
- Throughput: 1 byte/cycle within a burst. There is 1 idle cycle between bursts; the output register may still drain during it.
- Fairness: after releasing g, every other eligible requester is granted before g again.
- Simultaneous events:
  - Release and new requests in the same cycle: arbitration happens in the next S_IDLE cycle.
  - Masking a requester while it holds a byte in the output stage: that byte still completes.
- Reset mid-operation: the in-flight output byte is discarded; valid_o drops immediately (async).
- Width rules: beat_cnt is 8 bits; MAX_BURST=1 gives pure per-byte round robin.

Decomposition:
- Shared package piso_pkg holds the state encodings S_IDLE=1'b0 and S_GRANT=1'b1.
- It also holds the default NUM_REQ and MAX_BURST constants, for use by piso-side modules.
- One sub-module: rr_pick (combinational).
  - Inputs: elig[NUM_REQ], last_grant[ID_W].
  - Outputs: onehot[NUM_REQ], idx[ID_W], any.
  - Reusable by later schedulers.
- Output register and FSM live in piso_rr_arbiter.

Test Plan:
- Single requester: req 1 presents 0xA5,0x3C back-to-back, ready_i=1.
  - grant_o=4'b0010 one cycle after req_valid_i.
  - data_o sequence 0xA5,0x3C with src_o=1 on consecutive cycles; then S_IDLE.
- All four requesters continuously valid, MAX_BURST=4, ready_i=1:
  - Bursts of 4 bytes in order src 0,1,2,3,0.
  - Exactly 1 bubble cycle between bursts.
- Backpressure: ready_i=0 for 3 cycles mid-burst.
  - data_o/src_o stable and valid_o=1 throughout; req_ready_o[g]=0.
  - No byte lost or duplicated (scoreboard per source).
- Pause/mask:
  - Req 2 drops valid after 2 bytes → release, next grant goes to req 3.
  - Setting req_mask_i[3] mid-burst → release with no further req 3 accept; req 3 is never granted while masked.
- Fairness wrap: last_grant=3, only reqs 0 and 3 valid → req 0 granted before req 3.
- Async reset asserted while valid_o=1 and ready_i=0:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After deassert, requester 0 wins first arbitration.
